rs_alu: RTL

Reservation station for the ALU execution unit: buffers up to ENTRIES dispatched ALU micro-ops, wakes their source operands from two CDB broadcast ports, and issues one ready op per cycle into the ALU execution unit. Sits between dispatch/rename and the ALU execution unit. Issue outputs are registered and held so the single-cycle ALU sees stable operands in the cycle its finish strobe is high.

---
 rtl/rs_alu_pkg.sv | 33 +++
 rtl/rs_alu_if.sv | 57 +++++
 rtl/rs_alu_entry.sv | 107 ++++++++++
 rtl/rs_alu.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rs_alu_pkg.sv
// Shared widths and payload types for the ALU reservation station.
package rs_alu_pkg;

  localparam int unsigned ROB_TAG_WIDTH   = 4;
  localparam int unsigned ALU_OP_SEL      = 4;
  localparam int unsigned ALU_SRC1_SEL    = 2;
  localparam int unsigned ALU_SRC2_SEL    = 2;
  localparam int unsigned RV32_PC_WIDTH   = 32;
  localparam int unsigned RV32_DATA_WIDTH = 32;

  typedef enum logic [ALU_OP_SEL-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef logic [RV32_DATA_WIDTH-1:0] data_t;
  typedef logic [RV32_PC_WIDTH-1:0]   pc_t;

  typedef struct packed {
    logic [ALU_OP_SEL-1:0]   op_sel;
    logic [ALU_SRC1_SEL-1:0] src1_sel;
    logic [ALU_SRC2_SEL-1:0] src2_sel;
  } alu_ctrl_t;

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB, execution-unit back-pressure and issue bundle of the ALU station.
interface rs_alu_if #(
  parameter int unsigned TAG_W = rs_alu_pkg::ROB_TAG_WIDTH
);
  import rs_alu_pkg::*;

  logic                    i_flush;
  logic                    i_dp_vld;
  logic                    o_dp_rdy;
  logic [ALU_OP_SEL-1:0]   i_dp_op_sel;
  logic [ALU_SRC1_SEL-1:0] i_dp_src1_sel;
  logic [ALU_SRC2_SEL-1:0] i_dp_src2_sel;
  pc_t                     i_dp_pc;
  data_t                   i_dp_imm;
  logic                    i_dp_rs1_rdy;
  logic                    i_dp_rs2_rdy;
  data_t                   i_dp_rs1;
  data_t                   i_dp_rs2;
  logic [TAG_W-1:0]        i_dp_rs1_tag;
  logic [TAG_W-1:0]        i_dp_rs2_tag;
  logic [TAG_W-1:0]        i_dp_dst_tag;
  logic                    i_cdb0_vld;
  logic [TAG_W-1:0]        i_cdb0_tag;
  data_t                   i_cdb0_data;
  logic                    i_cdb1_vld;
  logic [TAG_W-1:0]        i_cdb1_tag;
  data_t                   i_cdb1_data;
  logic                    i_ex_busy;
  logic                    o_is_vld;
  logic [ALU_OP_SEL-1:0]   o_op_sel;
  logic [ALU_SRC1_SEL-1:0] o_src1_sel;
  logic [ALU_SRC2_SEL-1:0] o_src2_sel;
  data_t                   o_rs1;
  data_t                   o_rs2;
  pc_t                     o_pc;
  data_t                   o_imm;
  logic [TAG_W-1:0]        o_dst_tag;

  modport master (
    output i_flush, i_dp_vld, i_dp_op_sel, i_dp_src1_sel, i_dp_src2_sel, i_dp_pc, i_dp_imm,
           i_dp_rs1_rdy, i_dp_rs2_rdy, i_dp_rs1, i_dp_rs2, i_dp_rs1_tag, i_dp_rs2_tag,
           i_dp_dst_tag, i_cdb0_vld, i_cdb0_tag, i_cdb0_data, i_cdb1_vld, i_cdb1_tag,
           i_cdb1_data, i_ex_busy,
    input  o_dp_rdy, o_is_vld, o_op_sel, o_src1_sel, o_src2_sel, o_rs1, o_rs2, o_pc, o_imm,
           o_dst_tag
  );

  modport slave (
    input  i_flush, i_dp_vld, i_dp_op_sel, i_dp_src1_sel, i_dp_src2_sel, i_dp_pc, i_dp_imm,
           i_dp_rs1_rdy, i_dp_rs2_rdy, i_dp_rs1, i_dp_rs2, i_dp_rs1_tag, i_dp_rs2_tag,
           i_dp_dst_tag, i_cdb0_vld, i_cdb0_tag, i_cdb0_data, i_cdb1_vld, i_cdb1_tag,
           i_cdb1_data, i_ex_busy,
    output o_dp_rdy, o_is_vld, o_op_sel, o_src1_sel, o_src2_sel, o_rs1, o_rs2, o_pc, o_imm,
           o_dst_tag
  );

endinterface

// File: rtl/rs_alu_entry.sv
// One station entry: payload storage, dispatch-time CDB bypass and dual-port CDB wakeup.
module rs_alu_entry
  import rs_alu_pkg::*;
#(
  parameter int unsigned TAG_W = ROB_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic             issue_i,
  input  alu_ctrl_t        ctrl_i,
  input  pc_t              pc_i,
  input  data_t            imm_i,
  input  logic [TAG_W-1:0] dst_tag_i,
  input  logic             rs1_rdy_i,
  input  logic [TAG_W-1:0] rs1_tag_i,
  input  data_t            rs1_i,
  input  logic             rs2_rdy_i,
  input  logic [TAG_W-1:0] rs2_tag_i,
  input  data_t            rs2_i,
  input  logic             cdb0_vld_i,
  input  logic [TAG_W-1:0] cdb0_tag_i,
  input  data_t            cdb0_data_i,
  input  logic             cdb1_vld_i,
  input  logic [TAG_W-1:0] cdb1_tag_i,
  input  data_t            cdb1_data_i,
  output logic             valid_o,
  output logic             eligible_o,
  output alu_ctrl_t        ctrl_o,
  output pc_t              pc_o,
  output data_t            imm_o,
  output logic [TAG_W-1:0] dst_tag_o,
  output data_t            rs1_o,
  output data_t            rs2_o
);

  logic             valid_q;
  alu_ctrl_t        ctrl_q;
  pc_t              pc_q;
  data_t            imm_q;
  logic [TAG_W-1:0] dst_tag_q;
  logic [1:0]       rdy_q, rdy_d;
  logic [TAG_W-1:0] tag_q [2];
  data_t            data_q [2];
  data_t            data_d [2];

  logic [1:0]       cur_rdy, hit0, hit1;
  logic [TAG_W-1:0] cur_tag [2];
  data_t            cur_data [2];

  // Same match logic serves dispatch bypass (alloc) and wakeup of stored operands.
  always_comb begin
    cur_rdy[0]  = alloc_i ? rs1_rdy_i : rdy_q[0];
    cur_rdy[1]  = alloc_i ? rs2_rdy_i : rdy_q[1];
    cur_tag[0]  = alloc_i ? rs1_tag_i : tag_q[0];
    cur_tag[1]  = alloc_i ? rs2_tag_i : tag_q[1];
    cur_data[0] = alloc_i ? rs1_i     : data_q[0];
    cur_data[1] = alloc_i ? rs2_i     : data_q[1];
    for (int unsigned k = 0; k < 2; k++) begin
      hit0[k]   = !cur_rdy[k] && cdb0_vld_i && (cdb0_tag_i == cur_tag[k]);
      hit1[k]   = !cur_rdy[k] && cdb1_vld_i && (cdb1_tag_i == cur_tag[k]);
      rdy_d[k]  = cur_rdy[k] | hit0[k] | hit1[k];
      data_d[k] = hit0[k] ? cdb0_data_i : (hit1[k] ? cdb1_data_i : cur_data[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      dst_tag_q <= '0;
      rdy_q     <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      rdy_q <= rdy_d;
      for (int unsigned k = 0; k < 2; k++) begin
        data_q[k] <= data_d[k];
        if (alloc_i) tag_q[k] <= cur_tag[k];
      end
      if (alloc_i) begin
        ctrl_q    <= ctrl_i;
        pc_q      <= pc_i;
        imm_q     <= imm_i;
        dst_tag_q <= dst_tag_i;
      end
      if (flush_i)      valid_q <= 1'b0;
      else if (alloc_i) valid_q <= 1'b1;
      else if (issue_i) valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign eligible_o = valid_q & (&rdy_q);
  assign ctrl_o     = ctrl_q;
  assign pc_o       = pc_q;
  assign imm_o      = imm_q;
  assign dst_tag_o  = dst_tag_q;
  assign rs1_o      = data_q[0];
  assign rs2_o      = data_q[1];

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: free/ready priority encoders over the entries plus the issue register.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned TAG_W   = ROB_TAG_WIDTH
) (
  input logic    clk,
  input logic    rst_n,
  rs_alu_if.slave bus
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] valid, eligible, alloc, issue;
  alu_ctrl_t          ent_ctrl [ENTRIES];
  pc_t                ent_pc   [ENTRIES];
  data_t              ent_imm  [ENTRIES];
  logic [TAG_W-1:0]   ent_dst  [ENTRIES];
  data_t              ent_rs1  [ENTRIES];
  data_t              ent_rs2  [ENTRIES];

  alu_ctrl_t          dp_ctrl;
  logic               free_any, rdy_any, dp_fire, is_fire;
  logic [IDX_W-1:0]   free_idx, rdy_idx;

  logic               is_vld_q;
  alu_ctrl_t          is_ctrl_q;
  pc_t                is_pc_q;
  data_t              is_imm_q, is_rs1_q, is_rs2_q;
  logic [TAG_W-1:0]   is_dst_q;

  assign dp_ctrl = '{op_sel: bus.i_dp_op_sel, src1_sel: bus.i_dp_src1_sel,
                     src2_sel: bus.i_dp_src2_sel};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    rs_alu_entry #(.TAG_W(TAG_W)) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (bus.i_flush),
      .alloc_i     (alloc[g]),
      .issue_i     (issue[g]),
      .ctrl_i      (dp_ctrl),
      .pc_i        (bus.i_dp_pc),
      .imm_i       (bus.i_dp_imm),
      .dst_tag_i   (bus.i_dp_dst_tag),
      .rs1_rdy_i   (bus.i_dp_rs1_rdy),
      .rs1_tag_i   (bus.i_dp_rs1_tag),
      .rs1_i       (bus.i_dp_rs1),
      .rs2_rdy_i   (bus.i_dp_rs2_rdy),
      .rs2_tag_i   (bus.i_dp_rs2_tag),
      .rs2_i       (bus.i_dp_rs2),
      .cdb0_vld_i  (bus.i_cdb0_vld),
      .cdb0_tag_i  (bus.i_cdb0_tag),
      .cdb0_data_i (bus.i_cdb0_data),
      .cdb1_vld_i  (bus.i_cdb1_vld),
      .cdb1_tag_i  (bus.i_cdb1_tag),
      .cdb1_data_i (bus.i_cdb1_data),
      .valid_o     (valid[g]),
      .eligible_o  (eligible[g]),
      .ctrl_o      (ent_ctrl[g]),
      .pc_o        (ent_pc[g]),
      .imm_o       (ent_imm[g]),
      .dst_tag_o   (ent_dst[g]),
      .rs1_o       (ent_rs1[g]),
      .rs2_o       (ent_rs2[g])
    );
  end

  // Both encoders look at registered state, so a slot freed by this cycle's issue is not reused yet.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    rdy_any  = 1'b0;
    rdy_idx  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!valid[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
      if (eligible[i] && !rdy_any) begin
        rdy_any = 1'b1;
        rdy_idx = i[IDX_W-1:0];
      end
    end
    dp_fire = bus.i_dp_vld && free_any && !bus.i_flush;
    is_fire = rdy_any && !bus.i_ex_busy && !bus.i_flush;
    alloc   = '0;
    issue   = '0;
    if (dp_fire) alloc[free_idx] = 1'b1;
    if (is_fire) issue[rdy_idx]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_vld_q  <= 1'b0;
      is_ctrl_q <= '0;
      is_pc_q   <= '0;
      is_imm_q  <= '0;
      is_rs1_q  <= '0;
      is_rs2_q  <= '0;
      is_dst_q  <= '0;
    end else begin
      is_vld_q <= is_fire;
      if (is_fire) begin
        is_ctrl_q <= ent_ctrl[rdy_idx];
        is_pc_q   <= ent_pc[rdy_idx];
        is_imm_q  <= ent_imm[rdy_idx];
        is_rs1_q  <= ent_rs1[rdy_idx];
        is_rs2_q  <= ent_rs2[rdy_idx];
        is_dst_q  <= ent_dst[rdy_idx];
      end
    end
  end

  assign bus.o_dp_rdy   = free_any;
  assign bus.o_is_vld   = is_vld_q;
  assign bus.o_op_sel   = is_ctrl_q.op_sel;
  assign bus.o_src1_sel = is_ctrl_q.src1_sel;
  assign bus.o_src2_sel = is_ctrl_q.src2_sel;
  assign bus.o_pc       = is_pc_q;
  assign bus.o_imm      = is_imm_q;
  assign bus.o_rs1      = is_rs1_q;
  assign bus.o_rs2      = is_rs2_q;
  assign bus.o_dst_tag  = is_dst_q;

endmodule
